lcd_avm_master: RTL and testbench

- Avalon-MM master that turns a queued command stream into single-word read/write transfers on a PIO-style slave bus.
- Targets LCD chip-select, data and control PIO slaves.
- Sits between the LCD controller logic and the slave ports it programs.
- Buffers commands, holds bus signals stable under waitrequest, and returns one response per command.

---
 rtl/lcd_avm_master.sv | 156 +++++++++++++++
 tb/tb_lcd_avm_master.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_avm_master.sv
// Avalon-MM single-word master for LCD PIO slaves; LCD_AVM_MASTER_TIMEOUT_EN adds a stall-timeout abort.
// Strobe two cycles after command accept, response one cycle after completion; cmd_ready drops while the queue is full.
module lcd_avm_master #(
  parameter int ADDR_W      = 2,
  parameter int DATA_W      = 32,
  parameter int CMD_DEPTH   = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic              avm_read_n,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("lcd_avm_master: CMD_DEPTH must be a power of 2 >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  cmd_t             fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  state_t           state;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  cmd_t             head;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(CMD_DEPTH));
  assign cmd_ready = !reset && !full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && !empty;
  assign head      = fifo_mem[rd_ptr];
  assign busy      = (state != IDLE) || !empty || rsp_valid;

  // Storage is not reset; push is already blocked while reset is high.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= cmd_t'{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef LCD_AVM_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] stall_cnt;
  logic             rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_read_n     <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
`ifdef LCD_AVM_MASTER_TIMEOUT_EN
      stall_cnt      <= '0;
      rsp_err_q      <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            avm_address    <= head.addr;
            if (head.write) avm_writedata <= head.wdata;
            avm_chipselect <= 1'b1;
            avm_write_n    <= !head.write;
            avm_read_n     <= head.write;
            state          <= ISSUE;
`ifdef LCD_AVM_MASTER_TIMEOUT_EN
            stall_cnt      <= '0;
`endif
          end
        end
        ISSUE: begin
          // Completion takes priority over a timeout landing in the same cycle.
          if (!avm_waitrequest) begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_read_n     <= 1'b1;
            rsp_valid      <= 1'b1;
            rsp_rdata      <= avm_write_n ? avm_readdata : '0;
            state          <= IDLE;
`ifdef LCD_AVM_MASTER_TIMEOUT_EN
            rsp_err_q      <= 1'b0;
`endif
          end
`ifdef LCD_AVM_MASTER_TIMEOUT_EN
          else if (stall_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_read_n     <= 1'b1;
            rsp_valid      <= 1'b1;
            rsp_rdata      <= '0;
            rsp_err_q      <= 1'b1;
            state          <= IDLE;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_avm_master.sv
// Randomized and directed bench for lcd_avm_master against a queue-based transaction model.
`timescale 1ns/1ps
module tb_lcd_avm_master;
  localparam int AW = 2, DW = 32, DEPTH = 4, TMO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_err, busy;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] avm_address;
  logic          avm_chipselect, avm_write_n, avm_read_n;
  logic [DW-1:0] avm_writedata, avm_readdata;
  logic          avm_waitrequest;

  always #5 clk = ~clk;

  lcd_avm_master #(.ADDR_W(AW), .DATA_W(DW), .CMD_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_read_n(avm_read_n),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_s;

  cmd_s          cmd_q[$];
  int            n_checks = 0, n_fail = 0;
  int            fifo_cnt = 0, resp_cnt = 0, acc_cnt = 0, stall_run = 0;
  bit            rsp_due = 0, exp_err = 0, xfer_open = 0, prev_done = 0;
  logic [DW-1:0] exp_rdata = '0;
  int            hold, n, total, cyc, base;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: accepted commands wait in cmd_q until their bus transfer ends; each end owes one response next cycle.
  always @(negedge clk) begin
    if (reset) begin
      check("ready_in_reset", cmd_ready, 0);
      cmd_q.delete();
      fifo_cnt = 0; resp_cnt = 0; acc_cnt = 0; stall_run = 0;
      rsp_due = 0; xfer_open = 0; prev_done = 0;
    end else begin
      check("rsp_valid", rsp_valid, rsp_due);
      if (rsp_valid && rsp_due) begin
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", rsp_err, exp_err);
        resp_cnt++;
      end
      check("busy", busy, (cmd_q.size() != 0) || rsp_due);
      rsp_due = 0;
      if (avm_chipselect) begin
        check("no_back_to_back", prev_done, 0);
        check("xfer_pending", cmd_q.size() != 0, 1);
        if (!xfer_open) begin
          xfer_open = 1; fifo_cnt--; stall_run = 0;
        end
        if (cmd_q.size() != 0) begin
          check("bus_write_n", avm_write_n, !cmd_q[0].w);
          check("bus_read_n", avm_read_n, cmd_q[0].w);
          check("bus_address", avm_address, cmd_q[0].a);
          if (cmd_q[0].w) check("bus_writedata", avm_writedata, cmd_q[0].d);
          if (!avm_waitrequest) begin
            exp_rdata = cmd_q[0].w ? '0 : avm_readdata;
            exp_err = 0; rsp_due = 1; xfer_open = 0;
            void'(cmd_q.pop_front());
          end
`ifdef LCD_AVM_MASTER_TIMEOUT_EN
          else begin
            stall_run++;
            if (stall_run == TMO) begin
              exp_rdata = '0; exp_err = 1; rsp_due = 1; xfer_open = 0;
              void'(cmd_q.pop_front());
            end
          end
`endif
        end
      end else begin
        check("idle_write_n", avm_write_n, 1);
        check("idle_read_n", avm_read_n, 1);
      end
      prev_done = avm_chipselect && !xfer_open;
      check("cmd_ready", cmd_ready, fifo_cnt < DEPTH);
      if (cmd_valid && cmd_ready) begin
        cmd_q.push_back('{cmd_write, cmd_addr, cmd_wdata});
        fifo_cnt++; acc_cnt++;
      end
    end
  end

  task automatic push_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, output int cycles);
    bit acc;
    acc = 0; cycles = 0;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!acc && cycles < 50) begin
      @(negedge clk); acc = cmd_ready;
      @(posedge clk); #1; cycles++;
    end
    cmd_valid = 0;
    check("push_accept", acc, 1);
  endtask

  task automatic wait_resp(input int target, input int budget);
    int k;
    k = 0;
    while (resp_cnt < target && k < budget) begin
      @(posedge clk); #1; k++;
    end
    check("resp_count", resp_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    avm_readdata = '0; avm_waitrequest = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    #1;
    check("rst_cs", avm_chipselect, 0);
    check("rst_write_n", avm_write_n, 1);
    check("rst_read_n", avm_read_n, 1);
    check("rst_address", avm_address, 0);
    check("rst_writedata", avm_writedata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);

    // Zero-wait write: strobe at N+2, response at N+3
    cmd_valid = 1; cmd_write = 1; cmd_addr = '0; cmd_wdata = 32'h1;
    @(posedge clk); #1 cmd_valid = 0;
    check("lat_cs_n1", avm_chipselect, 0);
    @(posedge clk); #1;
    check("lat_cs_n2", avm_chipselect, 1);
    check("lat_write_n", avm_write_n, 0);
    check("lat_addr", avm_address, 0);
    check("lat_wdata", avm_writedata, 32'h1);
    @(posedge clk); #1;
    check("lat_rsp_valid", rsp_valid, 1);
    check("lat_rsp_rdata", rsp_rdata, 0);
    check("lat_rsp_err", rsp_err, 0);

    // Read held by three stall cycles
    avm_waitrequest = 1; avm_readdata = 32'h1;
    push_cmd(0, '0, $urandom, cyc);
    n = 0;
    while (!avm_chipselect && n < 10) begin @(posedge clk); #1; n++; end
    hold = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) avm_waitrequest = 0;
      hold += (avm_chipselect && !avm_read_n) ? 1 : 0;
      @(posedge clk); #1;
    end
    check("rd_hold_cycles", hold, 4);
    check("rd_rsp_valid", rsp_valid, 1);
    check("rd_rsp_rdata", rsp_rdata, 32'h1);

    // Five back-to-back commands into a stalled slave
    avm_waitrequest = 1; avm_readdata = $urandom; base = resp_cnt; total = 0;
    for (int k = 0; k < 5; k++) begin
      push_cmd(k[0], AW'(k), $urandom, cyc);
      total += cyc;
    end
    check("b2b_push_cycles", total, 5);
    check("b2b_ready_full", cmd_ready, 0);
    avm_waitrequest = 0;
    wait_resp(base + 5, 40);

    // Push and pop in the same cycle with three entries queued
    avm_waitrequest = 1; base = resp_cnt;
    for (int k = 0; k < 4; k++) push_cmd(~k[0], AW'(k), $urandom, cyc);
    check("pp_cs", avm_chipselect, 1);
    avm_waitrequest = 0;
    @(posedge clk); #1;
    avm_waitrequest = 1;
    check("pp_idle", avm_chipselect, 0);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 2'd3; cmd_wdata = $urandom;
    @(posedge clk); #1;
    check("pp_ready_three", cmd_ready, 1);
    cmd_write = 0; cmd_addr = 2'd2;
    @(posedge clk); #1;
    cmd_valid = 0;
    check("pp_ready_full", cmd_ready, 0);
    avm_waitrequest = 0; avm_readdata = $urandom;
    wait_resp(base + 6, 60);

    // Reset in the second stall cycle of a write with two queued behind it
    avm_waitrequest = 1;
    push_cmd(1, 2'd1, $urandom, cyc);
    push_cmd(0, 2'd2, $urandom, cyc);
    push_cmd(1, 2'd3, $urandom, cyc);
    check("mr_cs_stall", avm_chipselect, 1);
    reset = 1;
    @(posedge clk); #1;
    check("mr_cs", avm_chipselect, 0);
    check("mr_write_n", avm_write_n, 1);
    check("mr_rsp_valid", rsp_valid, 0);
    check("mr_busy", busy, 0);
    reset = 0; avm_waitrequest = 0;
    #1;
    check("mr_ready_after", cmd_ready, 1);
    repeat (6) begin @(posedge clk); #1; end
    check("mr_no_resp", resp_cnt, 0);
    check("mr_busy_after", busy, 0);

`ifdef LCD_AVM_MASTER_TIMEOUT_EN
    // Stuck slave: abort after TMO stall cycles, then the next command runs
    avm_waitrequest = 1; base = resp_cnt;
    push_cmd(0, 2'd1, $urandom, cyc);
    push_cmd(1, 2'd2, $urandom, cyc);
    hold = 0; n = 0;
    while (!rsp_valid && n < 30) begin
      hold += avm_chipselect ? 1 : 0;
      @(posedge clk); #1; n++;
    end
    check("tmo_cs_cycles", hold, TMO);
    check("tmo_rsp_valid", rsp_valid, 1);
    check("tmo_rsp_err", rsp_err, 1);
    check("tmo_rsp_rdata", rsp_rdata, 0);
    avm_waitrequest = 0;
    wait_resp(base + 2, 20);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr = AW'($urandom);
      cmd_wdata = $urandom;
      avm_waitrequest = ($urandom_range(0, 99) < 45);
      avm_readdata = $urandom;
      @(posedge clk); #1;
    end
    cmd_valid = 0; avm_waitrequest = 0;
    n = 0;
    while (busy && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    check("drain_busy", busy, 0);
    check("drain_all_resp", resp_cnt, acc_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
